pll_lock_monitor: RTL and testbench

Single-clock monitor that receives one PLL output clock as a sampled data signal, measures its period in system-clock cycles and declares lock after a run of in-tolerance periods. It is the consuming end of the simulated PLL's `clk_out`/`locked` interface: it checks that a delivered clock is actually at the expected frequency and produces an independent lock indication. The monitor feeds emulation-shell bring-up logic and status registers.

---
 rtl/pll_lock_monitor.sv | 162 ++++++++++++++++
 tb/tb_pll_lock_monitor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: measures the period of a sampled monitored clock in clk
// cycles and declares lock after a run of in-tolerance periods.
// Optional build macro: LOCK_MON_STATS_EN enables the saturating bad-period
// counter on err_count. When the macro is undefined, err_count is tied to 0.
module pll_lock_monitor #(
  parameter int EXP_PERIOD   = 8,
  parameter int TOL          = 1,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mon_clk,
  input  logic             enable,
  output logic             locked,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [7:0]       err_count
);

  localparam int RUN_W = 8;
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(4 * EXP_PERIOD);
  localparam logic [CNT_W-1:0] GOOD_LO = CNT_W'((EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0);
  localparam logic [CNT_W-1:0] GOOD_HI = CNT_W'(EXP_PERIOD + TOL);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic [CNT_W-1:0] period_q, meas_val;
  logic             pv_q;
  logic             s1_q, s2_q, s3_q;
  logic             rise, tmo, meas, good, take;

  // Two-flop synchronizer plus a history flop for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= mon_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Measurement event: a rising edge, or a timeout when the clock is stuck.
  // An edge takes priority over a timeout that lands in the same cycle.
  always_comb begin
    rise     = s2_q & ~s3_q;
    cnt_inc  = cnt_q + CNT_W'(1);
    tmo      = (cnt_inc == TMO_VAL);
    meas     = rise | tmo;
    meas_val = rise ? cnt_inc : TMO_VAL;
    good     = (meas_val >= GOOD_LO) && (meas_val <= GOOD_HI);
    // Only measurements in TRACK/LOCKED are reported. The ACQUIRE one is partial.
    take     = enable && meas && ((state_q == TRACK) || (state_q == LOCKED));
  end

  // State and run-counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Next-state logic: good/bad run counting toward lock and unlock
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (!enable) begin
      state_d = IDLE;
      run_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          run_d   = '0;
        end
        ACQUIRE: begin
          if (meas) begin
            state_d = TRACK;
            run_d   = '0;
          end
        end
        TRACK: begin
          if (meas) begin
            if (!good) begin
              run_d = '0;
            end else if (run_q + RUN_W'(1) == RUN_W'(LOCK_COUNT)) begin
              state_d = LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end
        end
        LOCKED: begin
          if (meas) begin
            if (good) begin
              run_d = '0;
            end else if (run_q + RUN_W'(1) == RUN_W'(UNLOCK_COUNT)) begin
              state_d = TRACK;
              run_d   = '0;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
    end
  end

  // Output decode: lock is a pure function of the registered state
  always_comb begin
    locked = (state_q == LOCKED);
  end

  // Period counter and reported period. The period holds across IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
    end else begin
      if (!enable || state_q == IDLE) cnt_q <= '0;
      else if (meas)                  cnt_q <= '0;
      else                            cnt_q <= cnt_inc;
      if (take) period_q <= meas_val;
      pv_q <= take;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;

`ifdef LOCK_MON_STATS_EN
  logic [7:0] err_q;

  // Saturating count of bad periods seen while tracking or locked
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          err_q <= '0;
    else if (take && !good && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Randomized bench for pll_lock_monitor. Monitored-clock intervals are chosen
// by the bench. Each interval is expanded arithmetically into the period
// reports it must cause, and the lock/err rules are applied to that list.
module tb_pll_lock_monitor;
  localparam int EXP  = 8;
  localparam int TOL  = 1;
  localparam int LCK  = 4;
  localparam int ULK  = 2;
  localparam int TMO  = 4 * EXP;
`ifdef LOCK_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mon_clk = 1'b0;
  logic        enable = 1'b0;
  logic        locked;
  logic [15:0] period;
  logic        period_valid;
  logic [7:0]  err_count;

  pll_lock_monitor #(
    .EXP_PERIOD(EXP), .TOL(TOL), .LOCK_COUNT(LCK), .UNLOCK_COUNT(ULK), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mon_clk(mon_clk), .enable(enable),
    .locked(locked), .period(period), .period_valid(period_valid),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct { int p; bit lk; int err; } meas_t;
  meas_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    m_locked = 1'b0;
  int    m_run = 0;
  int    m_err = 0;
  int    tbl[8] = '{8, 8, 8, 7, 9, 6, 10, 40};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One reported period: apply the good/bad run rules at measurement level
  function automatic void model_meas(input int p);
    bit good;
    good = (p >= EXP - TOL) && (p <= EXP + TOL);
    if (!good && STATS && m_err < 255) m_err++;
    if (!m_locked) begin
      m_run = good ? m_run + 1 : 0;
      if (m_run == LCK) begin m_locked = 1'b1; m_run = 0; end
    end else begin
      m_run = good ? 0 : m_run + 1;
      if (m_run == ULK) begin m_locked = 1'b0; m_run = 0; end
    end
    exp_q.push_back('{p, m_locked, m_err});
  endfunction

  // An interval of L cycles between rises yields full timeouts, then the remainder
  function automatic void push_interval(input int L);
    int n;
    n = (L - 1) / TMO;
    for (int i = 0; i < n; i++) model_meas(TMO);
    model_meas(L - TMO * n);
  endfunction

  // Rise now (at a negedge), the next rise comes L cycles later
  task automatic mon_period(input int L);
    push_interval(L);
    mon_clk = 1'b1;
    repeat (L / 2) @(negedge clk);
    mon_clk = 1'b0;
    repeat (L - L / 2) @(negedge clk);
  endtask

  task automatic start_session();
    m_locked = 1'b0;
    m_run    = 0;
    enable   = 1'b1;
    @(negedge clk);
  endtask

  // Closing rise ends the last interval. Then every expected report must be consumed.
  task automatic close_session(input string tag);
    mon_clk = 1'b1;
    repeat (2) @(negedge clk);
    mon_clk = 1'b0;
    repeat (4) @(negedge clk);
    chk({tag, "_drain"}, exp_q.size(), 0);
    chk({tag, "_lock"}, locked, m_locked);
  endtask

  task automatic stop_enable(input string tag);
    enable = 1'b0;
    @(negedge clk);
    chk({tag, "_dis_lock"}, locked, 0);
    m_locked = 1'b0;
    m_run    = 0;
    repeat (20) @(negedge clk);
  endtask

  task automatic rand_session(input string tag, input int n);
    start_session();
    repeat (n) mon_period(tbl[$urandom_range(0, 7)]);
    close_session(tag);
  endtask

  // Every period_valid pulse consumes one expected report
  always @(negedge clk) begin
    if (reset_n && period_valid) begin
      if (exp_q.size() == 0) begin
        chk("stray_pv", 1, 0);
      end else begin
        meas_t e;
        e = exp_q.pop_front();
        chk("period", period, e.p);
        chk("locked", locked, e.lk);
        chk("err_count", err_count, e.err);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_period", period, 0);
    chk("rst_pv", period_valid, 0);
    chk("rst_err", err_count, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed: lock, frequency step, tolerance edges, isolated bad, stuck clock
    start_session();
    repeat (6) mon_period(8);
    repeat (3) mon_period(10);
    repeat (6) mon_period(8);
    repeat (3) begin mon_period(6); mon_period(8); end
    mon_period(7); mon_period(9); mon_period(7); mon_period(9);
    mon_period(6); mon_period(6);
    repeat (5) mon_period(8);
    mon_period(75);
    repeat (5) mon_period(8);
    close_session("dir");
    stop_enable("dir");

    rand_session("rnd1", 30);
    stop_enable("rnd1");

    // Asynchronous reset in the middle of a lock
    start_session();
    repeat (6) mon_period(8);
    close_session("prerst");
    chk("prerst_locked", locked, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_period", period, 0);
    chk("arst_err", err_count, 0);
    exp_q.delete();
    m_err = 0; m_locked = 1'b0; m_run = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    repeat (4) mon_period(8);
    close_session("reacq");
    chk("reacq_locked", locked, 1);
    stop_enable("reacq");

    rand_session("rnd2", 60);
    stop_enable("rnd2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
